// File: rtl/mem_access_stage.sv
// Memory-access stage: drives the data-memory handshake, raises the pipeline stall and holds the MEM/WB register.
// Latency: zero-wait access lands in WB one edge later; N-cycle ack adds N stall cycles; no ack force-completes at TIMEOUT.
// Backpressure: mem_stall freezes the upstream stages while an access waits; WB receives bubbles meanwhile.
module mem_access_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_MemWrite,
    input  logic        MEM_MemRead,
    input  logic        MEM_MemtoReg,
    input  logic        MEM_RegWrite,
    input  logic [15:0] MEM_ALUval,
    input  logic [15:0] MEM_ReadData2,
    input  logic [3:0]  MEM_DstReg,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        mem_stall,
    output logic        mem_err,
    output logic [15:0] stall_cycles,
    output logic        WB_RegWrite,
    output logic        WB_MemtoReg,
    output logic [15:0] WB_ALUval,
    output logic [15:0] WB_MemData,
    output logic [3:0]  WB_DstReg
);
    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t      state_q;
    logic [7:0]  wait_q;
    logic        err_q;
    logic [15:0] stall_cnt_q;
    logic        wb_regwrite_q;
    logic        wb_memtoreg_q;
    logic [15:0] wb_aluval_q;
    logic [15:0] wb_memdata_q;
    logic [3:0]  wb_dstreg_q;

    logic access;
    logic busy;
    logic is_load;
    logic timeout;
    logic complete;

    assign access   = MEM_MemWrite | MEM_MemRead;
    assign busy     = (state_q == BUSY);
    // A store wins when both read and write are requested, so only a pure read is a load.
    assign is_load  = MEM_MemRead & ~MEM_MemWrite;
    assign timeout  = busy & (wait_q == TIMEOUT_CNT) & ~mem_ack;
    assign complete = mem_ack | timeout;

    assign mem_req   = busy | access;
    assign mem_wr    = MEM_MemWrite;
    assign mem_addr  = MEM_ALUval;
    assign mem_wdata = MEM_ReadData2;
    assign mem_stall = mem_req & ~complete;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            wait_q        <= 8'd0;
            err_q         <= 1'b0;
            stall_cnt_q   <= 16'd0;
            wb_regwrite_q <= 1'b0;
            wb_memtoreg_q <= 1'b0;
            wb_aluval_q   <= 16'd0;
            wb_memdata_q  <= 16'd0;
            wb_dstreg_q   <= 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (access && !mem_ack) begin
                        state_q <= BUSY;
                        wait_q  <= 8'd1;
                    end
                end
                BUSY: begin
                    if (complete) begin
                        state_q <= IDLE;
                        wait_q  <= 8'd0;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    wait_q  <= 8'd0;
                end
            endcase

            if (timeout) begin
                err_q <= 1'b1;
            end

            if (mem_stall && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end

            if (mem_stall) begin
                wb_regwrite_q <= 1'b0;
                wb_memtoreg_q <= 1'b0;
            end else begin
                wb_regwrite_q <= MEM_RegWrite;
                wb_memtoreg_q <= MEM_MemtoReg;
                wb_aluval_q   <= MEM_ALUval;
                wb_dstreg_q   <= MEM_DstReg;
                if (mem_req && is_load && mem_ack) begin
                    wb_memdata_q <= mem_rdata;
                end else if (timeout && is_load) begin
                    wb_memdata_q <= 16'h0000;
                end
            end
        end
    end

    assign mem_err      = err_q;
    assign stall_cycles = stall_cnt_q;
    assign WB_RegWrite  = wb_regwrite_q;
    assign WB_MemtoReg  = wb_memtoreg_q;
    assign WB_ALUval    = wb_aluval_q;
    assign WB_MemData   = wb_memdata_q;
    assign WB_DstReg    = wb_dstreg_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios plus random instruction streams against a transaction-level model.
module tb_mem_access_stage;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        MEM_MemWrite = 1'b0;
    logic        MEM_MemRead = 1'b0;
    logic        MEM_MemtoReg = 1'b0;
    logic        MEM_RegWrite = 1'b0;
    logic [15:0] MEM_ALUval = '0;
    logic [15:0] MEM_ReadData2 = '0;
    logic [3:0]  MEM_DstReg = '0;
    logic        mem_req;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic        mem_stall;
    logic        mem_err;
    logic [15:0] stall_cycles;
    logic        WB_RegWrite;
    logic        WB_MemtoReg;
    logic [15:0] WB_ALUval;
    logic [15:0] WB_MemData;
    logic [3:0]  WB_DstReg;

    mem_access_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .MEM_MemWrite(MEM_MemWrite), .MEM_MemRead(MEM_MemRead),
        .MEM_MemtoReg(MEM_MemtoReg), .MEM_RegWrite(MEM_RegWrite),
        .MEM_ALUval(MEM_ALUval), .MEM_ReadData2(MEM_ReadData2), .MEM_DstReg(MEM_DstReg),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .mem_stall(mem_stall), .mem_err(mem_err), .stall_cycles(stall_cycles),
        .WB_RegWrite(WB_RegWrite), .WB_MemtoReg(WB_MemtoReg),
        .WB_ALUval(WB_ALUval), .WB_MemData(WB_MemData), .WB_DstReg(WB_DstReg)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Architectural state expected after each retired instruction.
    logic        m_rw, m_mtr, m_err;
    logic [15:0] m_alu, m_md;
    logic [3:0]  m_dst;
    int          m_stalls;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rw = 0; m_mtr = 0; m_err = 0; m_alu = 0; m_md = 0; m_dst = 0; m_stalls = 0;
    endtask

    // Called at a negedge; ack_lat < 0 or > TO means memory never answers.
    task automatic run_instr(input logic we, input logic re, input logic mtr, input logic rw,
                             input logic [15:0] alu, input logic [15:0] wd, input logic [3:0] dst,
                             input int ack_lat, input logic [15:0] rd);
        logic acc, ld, acked;
        int   len;
        acc = we | re;
        ld  = re & ~we;
        acked = 1'b0;
        if (!acc) len = 0;
        else if (ack_lat >= 0 && ack_lat <= TO) begin len = ack_lat; acked = 1'b1; end
        else len = TO;
        for (int k = 0; k <= len; k++) begin
            MEM_MemWrite = we; MEM_MemRead = re; MEM_MemtoReg = mtr; MEM_RegWrite = rw;
            MEM_ALUval = alu; MEM_ReadData2 = wd; MEM_DstReg = dst;
            mem_ack   = acc ? (acked && k == len) : 1'($urandom_range(0, 1));
            mem_rdata = (acc && mem_ack) ? rd : 16'($urandom);
            #1;
            check("req", {31'd0, mem_req}, {31'd0, acc});
            check("stall", {31'd0, mem_stall}, {31'd0, (k < len)});
            if (acc) begin
                check("wr", {31'd0, mem_wr}, {31'd0, we});
                check("addr", {16'd0, mem_addr}, {16'd0, alu});
                check("wdata", {16'd0, mem_wdata}, {16'd0, wd});
            end
            @(negedge clk);
            if (k < len) begin
                if (m_stalls < 16'hFFFF) m_stalls++;
                check("bubble_rw", {31'd0, WB_RegWrite}, 32'd0);
                check("bubble_mtr", {31'd0, WB_MemtoReg}, 32'd0);
                check("bubble_alu", {16'd0, WB_ALUval}, {16'd0, m_alu});
                check("stall_cnt", {16'd0, stall_cycles}, m_stalls);
            end
        end
        mem_ack = 1'b0;
        m_rw = rw; m_mtr = mtr; m_alu = alu; m_dst = dst;
        if (ld) m_md = acked ? rd : 16'h0000;
        if (acc && !acked) m_err = 1'b1;
        check("wb_rw", {31'd0, WB_RegWrite}, {31'd0, m_rw});
        check("wb_mtr", {31'd0, WB_MemtoReg}, {31'd0, m_mtr});
        check("wb_alu", {16'd0, WB_ALUval}, {16'd0, m_alu});
        check("wb_dst", {28'd0, WB_DstReg}, {28'd0, m_dst});
        check("wb_md", {16'd0, WB_MemData}, {16'd0, m_md});
        check("stall_cnt", {16'd0, stall_cycles}, m_stalls);
        check("err", {31'd0, mem_err}, {31'd0, m_err});
    endtask

    task automatic check_zero_state();
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_stall", {31'd0, mem_stall}, 32'd0);
        check("rst_rw", {31'd0, WB_RegWrite}, 32'd0);
        check("rst_mtr", {31'd0, WB_MemtoReg}, 32'd0);
        check("rst_alu", {16'd0, WB_ALUval}, 32'd0);
        check("rst_md", {16'd0, WB_MemData}, 32'd0);
        check("rst_dst", {28'd0, WB_DstReg}, 32'd0);
        check("rst_cnt", {16'd0, stall_cycles}, 32'd0);
        check("rst_err", {31'd0, mem_err}, 32'd0);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_zero_state();
        rst = 1'b0;

        for (int i = 0; i < 3; i++) run_instr(0, 0, 0, 1, 16'h1234, 16'h0, 4'd5, -1, 16'h0);
        run_instr(0, 1, 1, 1, 16'h0040, 16'h0, 4'd3, 0, 16'hBEEF);
        run_instr(1, 0, 0, 0, 16'h0010, 16'hA5A5, 4'd0, 3, 16'h0);
        run_instr(0, 1, 1, 1, 16'h0020, 16'h0, 4'd7, -1, 16'h0);
        run_instr(1, 1, 0, 0, 16'h0030, 16'h5A5A, 4'd0, 0, 16'h0);
        run_instr(0, 1, 1, 1, 16'h0050, 16'h0, 4'd2, 0, 16'hC0DE);
        run_instr(1, 0, 0, 0, 16'h0052, 16'h1111, 4'd0, 0, 16'h0);
        run_instr(0, 1, 1, 1, 16'h0060, 16'h0, 4'd9, TO, 16'h7777);

        // Abort a load two cycles into BUSY.
        MEM_MemRead = 1; MEM_MemWrite = 0; MEM_RegWrite = 1; MEM_MemtoReg = 1;
        MEM_ALUval = 16'h0070; MEM_DstReg = 4'd4; mem_ack = 0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("pre_abort_stall", {31'd0, mem_stall}, 32'd1);
        rst = 1'b1;
        MEM_MemRead = 0; MEM_RegWrite = 0; MEM_MemtoReg = 0;
        #1;
        check_zero_state();
        @(negedge clk);
        rst = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 16'hDEAD;
        #1;
        check("late_ack_req", {31'd0, mem_req}, 32'd0);
        @(negedge clk);
        mem_ack = 1'b0;
        model_reset();
        check("late_ack_md", {16'd0, WB_MemData}, 32'd0);
        check("late_ack_cnt", {16'd0, stall_cycles}, 32'd0);

        for (int i = 0; i < 300; i++) begin
            int kind;
            kind = $urandom_range(0, 3);
            run_instr(kind == 2 || kind == 3, kind == 1 || kind == 3,
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      16'($urandom), 16'($urandom), 4'($urandom),
                      $urandom_range(0, TO + 2), 16'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
